// File: rtl/pixel_loader_ctrl.sv
// HPS pixel PIO sequencer: decodes handshaked commands, tracks the row,
// and writes pixels into the VGA framebuffer over a valid/ready port.
//
// Ports:
//   clk_clk, reset_reset        : clock, synchronous active-high reset
//   pixel_data_export           : pixel value from HPS (PIX_W)
//   pixel_index_in_row_export   : column index from HPS (16)
//   pixel_status_write_export   : HPS command code (4)
//   pixel_row_export            : row the controller expects next (16)
//   pixel_status_read_export    : {done, error, busy, ack}
//   fb_we/fb_addr/fb_wdata      : framebuffer write request
//   fb_ready                    : framebuffer accepts when fb_we && fb_ready
//   frame_done                  : one-cycle pulse when the last row ends
module pixel_loader_ctrl #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 24
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [PIX_W-1:0]  pixel_data_export,
  input  logic [15:0]       pixel_index_in_row_export,
  input  logic [3:0]        pixel_status_write_export,
  output logic [15:0]       pixel_row_export,
  output logic [3:0]        pixel_status_read_export,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_wdata,
  input  logic              fb_ready,
  output logic              frame_done
);

  localparam logic [3:0] CMD_NOP   = 4'h0;
  localparam logic [3:0] CMD_FRAME = 4'h1;
  localparam logic [3:0] CMD_PIXEL = 4'h2;
  localparam logic [3:0] CMD_ROW   = 4'h3;
  localparam logic [3:0] CMD_ABORT = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ACK,
    RELEASE
  } state_t;

  state_t state, state_n;

  logic [3:0]        cmd_q;
  logic [15:0]       idx_q;
  logic [PIX_W-1:0]  data_q;

  logic [15:0]       row, row_n;
  logic [ADDR_W-1:0] row_base, row_base_n;
  logic              in_frame, in_frame_n;
  logic              err, err_n;
  logic              done, done_n;
  logic              ack, ack_n;
  logic              busy, busy_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [PIX_W-1:0]  wdata_n;
  logic              fd_n;

  logic is_nop, is_frame, is_pixel, is_row, is_abort;
  logic idx_ok, last_row;

  assign is_nop   = cmd_q == CMD_NOP;
  assign is_frame = cmd_q == CMD_FRAME;
  assign is_pixel = cmd_q == CMD_PIXEL;
  assign is_row   = cmd_q == CMD_ROW;
  assign is_abort = cmd_q == CMD_ABORT;

  assign idx_ok   = idx_q < 16'(H_RES);
  assign last_row = row == 16'(V_RES - 1);

  always_comb begin
    state_n    = state;
    row_n      = row;
    row_base_n = row_base;
    in_frame_n = in_frame;
    err_n      = err;
    done_n     = done;
    ack_n      = ack;
    busy_n     = busy;
    we_n       = fb_we;
    addr_n     = fb_addr;
    wdata_n    = fb_wdata;
    fd_n       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!is_nop) begin
          busy_n  = 1'b1;
          state_n = ACK;
        end
        unique case (1'b1)
          is_nop: ;
          is_frame: begin
            row_n      = '0;
            row_base_n = '0;
            in_frame_n = 1'b1;
            err_n      = 1'b0;
            done_n     = 1'b0;
          end
          is_pixel: begin
            if (in_frame && idx_ok) begin
              addr_n  = row_base + ADDR_W'(idx_q);
              wdata_n = data_q;
              we_n    = 1'b1;
              state_n = WRITE;
            end else begin
              err_n = 1'b1;
            end
          end
          is_row: begin
            if (!in_frame) begin
              err_n = 1'b1;
            end else if (last_row) begin
              row_n      = '0;
              row_base_n = '0;
              in_frame_n = 1'b0;
              done_n     = 1'b1;
              fd_n       = 1'b1;
            end else begin
              row_n      = row + 16'd1;
              row_base_n = row_base + ADDR_W'(H_RES);
            end
          end
          is_abort: begin
            row_n      = '0;
            row_base_n = '0;
            in_frame_n = 1'b0;
          end
          default: err_n = 1'b1;
        endcase
      end
      WRITE: begin
        if (fb_ready) begin
          we_n    = 1'b0;
          state_n = ACK;
        end
      end
      ACK: begin
        ack_n   = 1'b1;
        busy_n  = 1'b1;
        state_n = RELEASE;
      end
      RELEASE: begin
        // ack stays up until the HPS returns to NOP
        busy_n = 1'b0;
        if (is_nop) begin
          ack_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      cmd_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      row        <= '0;
      row_base   <= '0;
      in_frame   <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cmd_q      <= pixel_status_write_export;
      idx_q      <= pixel_index_in_row_export;
      data_q     <= pixel_data_export;
      row        <= row_n;
      row_base   <= row_base_n;
      in_frame   <= in_frame_n;
      err        <= err_n;
      done       <= done_n;
      ack        <= ack_n;
      busy       <= busy_n;
      fb_we      <= we_n;
      fb_addr    <= addr_n;
      fb_wdata   <= wdata_n;
      frame_done <= fd_n;
    end
  end

  assign pixel_row_export         = row;
  assign pixel_status_read_export = {done, err, busy, ack};

endmodule

// File: doc/pixel_loader_ctrl.md
Name: pixel_loader_ctrl

Overview:
- FPGA-side sequencer for the HPS pixel PIO channel: pixel_data, pixel_index_in_row, pixel_status_write in; pixel_row, pixel_status_read out.
- Decodes HPS commands under a 4-phase handshake.
- Tracks the current row and computes framebuffer addresses.
- Drives a valid/ready write port into the VGA framebuffer; pulses frame_done toward the VGA scan-out for buffer swap.

Parameters:
H_RES, 160, pixels per row
V_RES, 120, rows per frame
ADDR_W, 15, framebuffer address width (H_RES*V_RES must be <= 2**ADDR_W)
PIX_W, 24, pixel width (RGB888)

Ports:
clk_clk  in  1  system clock, single domain shared with the HPS PIO bridge
reset_reset  in  1  synchronous, active-high reset
pixel_data_export  in  PIX_W  pixel value from HPS
pixel_index_in_row_export  in  16  column index from HPS
pixel_status_write_export  in  4  HPS command code
pixel_row_export  out  16  row the controller currently expects
pixel_status_read_export  out  4  status to HPS: [0] ack, [1] busy, [2] error, [3] frame_done
fb_we  out  1  framebuffer write valid
fb_addr  out  ADDR_W  framebuffer write address
fb_wdata  out  PIX_W  framebuffer write data
fb_ready  in  1  framebuffer accepts write when fb_we&&fb_ready
frame_done  out  1  one-cycle pulse on frame completion

Behaviour:
- Reset: all outputs 0; FSM=IDLE; row=0; row_base=0; in_frame=0; error=0; done=0. Reset mid-write drops fb_we in the next cycle with no completion.
- Inputs registered once (cmd_q, idx_q, data_q); FSM acts on the registered values only.
- Command codes: 0 NOP, 1 FRAME_START, 2 PIXEL, 3 ROW_END, F ABORT; all others illegal.
- FSM states: IDLE, WRITE, ACK, RELEASE.
- IDLE, busy=0:
  - cmd_q==0: stay in IDLE.
  - FRAME_START: row=0, row_base=0, in_frame=1, error=0, done=0; go to ACK.
  - PIXEL with in_frame && idx_q<H_RES: latch fb_addr=row_base+idx_q, fb_wdata=data_q; go to WRITE.
  - PIXEL with !in_frame or idx_q>=H_RES: error=1, no write; go to ACK.
  - ROW_END with in_frame, row<V_RES-1: row+=1, row_base+=H_RES (no multiplier); go to ACK.
  - ROW_END with in_frame, row==V_RES-1: row=0, row_base=0, in_frame=0, done=1, frame_done pulses once; go to ACK.
  - ROW_END with !in_frame: error=1; go to ACK.
  - ABORT: in_frame=0, row=0, row_base=0; go to ACK. error and done are unchanged.
  - Illegal code: error=1; go to ACK.
- WRITE, busy=1:
  - fb_we=1, with fb_addr and fb_wdata held stable until fb_ready.
  - On fb_we&&fb_ready: fb_we=0 the next cycle; go to ACK.
  - Command changes during WRITE are ignored.
- ACK: ack=1, busy=1. Go to RELEASE the same cycle.
- RELEASE: ack held at 1 until cmd_q==0, then ack=0, busy=0; go to IDLE.
  - A non-zero command never retriggers without an intervening NOP.
- Latency: PIXEL on status_write at edge N puts fb_we=1 at edge N+2. With fb_ready=1, ack=1 at edge N+4. A non-pixel command gives ack=1 at edge N+3.
- pixel_row_export = row, updated in the same cycle as the row advance (before ack rises).
- error and done are sticky; only FRAME_START or reset clears them. An error never blocks subsequent commands.
- FRAME_START mid-frame restarts at row 0; pixels already written remain in memory.
- Index 0xFFFF and indices >= H_RES are rejected identically.

Test Plan:
- Reset, then idle: all outputs 0, pixel_row=0, status=0x0; held 0 for 10 cycles with status_write=0.
- FRAME_START, NOP; ROW_END x5; PIXEL idx=7 data=0xA1B2C3, fb_ready=1 -> pixel_row=5; fb_addr=807 (5*160+7), fb_wdata=0xA1B2C3 for exactly 1 cycle; ack=1 until NOP, then status=0x0.
- PIXEL idx=3 with fb_ready=0 for 6 cycles -> fb_we high 7 cycles; addr/data stable throughout; busy=1; ack only after acceptance.
- PIXEL idx=160 in frame, and PIXEL before any FRAME_START -> no fb_we; status=0x5 (ack+error) while held; error remains 1 after NOP until the next FRAME_START.
- Full frame: FRAME_START, 120 ROW_ENDs -> frame_done pulses 1 cycle on the 120th; pixel_row=0; status[3]=1; a further PIXEL sets error.
- Hold PIXEL code for 20 cycles -> exactly one fb write. ABORT mid-frame at row 40 -> pixel_row=0, in_frame cleared, next PIXEL sets error. Reset asserted during WRITE -> fb_we=0 next cycle.
